// File: rtl/occamy_pkg.sv
// Shared constants for the packet admission write stage of the 128b x 256 cell FIFO.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: cell geometry, FIFO depth and count widths, FSM state encoding,
//   and the byte-length to cell-count conversion.
package occamy_pkg;

  localparam int DW         = 128;
  localparam int CELL_BYTES = DW / 8;
  localparam int DEPTH      = 256;
  localparam int CNT_W      = 9;
  localparam int LEN_W      = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Round a byte length up to whole 16-byte cells. The extra top bit keeps
  // the carry of len + 15, so 2047 B yields 128 cells rather than wrapping.
  function automatic logic [7:0] len2cells(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W + 1)'(CELL_BYTES - 1);
    return sum[LEN_W:4];
  endfunction

endpackage

// File: rtl/pkt_admit_calc.sv
// Admission decision for a packet at its SOP beat: cells vs. free FIFO room.
// Latency: combinational.
// Backpressure: none; the result is only consumed on an SOP beat.
// Ports: in_len (packet bytes), fifo_data_count / fifo_wr_en (current and
//   in-flight occupancy), cfg_thresh (admit limit) -> cells, admit.
module pkt_admit_calc
  import occamy_pkg::*;
(
  input  logic [LEN_W-1:0] in_len,
  input  logic [CNT_W-1:0] fifo_data_count,
  input  logic             fifo_wr_en,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [7:0]       cells,
  output logic             admit
);

  logic [CNT_W-1:0] limit;
  logic [9:0]       need;

  assign cells = len2cells(in_len);

  // A threshold above the physical depth is meaningless; clamp it.
  assign limit = (cfg_thresh > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_thresh;

  // The registered write issued last cycle is not yet reflected in
  // fifo_data_count, so it is added back in here.
  assign need = {1'b0, fifo_data_count} + {9'b0, fifo_wr_en} + {2'b0, cells};

  assign admit = (in_len != '0) && (need <= {1'b0, limit});

endmodule

// File: rtl/pkt_admit_writer.sv
// Per-packet admit/drop in front of the cell FIFO; admitted cells are written, dropped packets discarded whole.
// Latency: an accepted beat at cycle t drives fifo_wr_en/fifo_din in cycle t+1.
// Backpressure: none; in_ready is held high out of reset and overflow is handled by dropping.
// Ports: clk/rst (sync, active-high); in_* cell stream with SOP/EOP and SOP length;
//   cfg_thresh admit limit; fifo_data_count/fifo_full status in, fifo_din/fifo_wr_en out;
//   pkt_acc_cnt/pkt_drop_cnt statistics; err_sticky protocol/overflow flag.
module pkt_admit_writer
  import occamy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [DW-1:0]    in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             in_ready,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic [CNT_W-1:0] fifo_data_count,
  input  logic             fifo_full,
  output logic [DW-1:0]    fifo_din,
  output logic             fifo_wr_en,
  output logic [31:0]      pkt_acc_cnt,
  output logic [31:0]      pkt_drop_cnt,
  output logic             err_sticky
);

  logic [1:0] state, state_nxt;
  logic [7:0] rem, rem_nxt;
  logic       wr_nxt, acc_inc, drop_inc, err_set;
  logic       beat;
  logic [7:0] cells;
  logic       admit;

  assign beat = in_valid & in_ready;

  pkt_admit_calc u_calc (
    .in_len          (in_len),
    .fifo_data_count (fifo_data_count),
    .fifo_wr_en      (fifo_wr_en),
    .cfg_thresh      (cfg_thresh),
    .cells           (cells),
    .admit           (admit)
  );

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    wr_nxt    = 1'b0;
    acc_inc   = 1'b0;
    drop_inc  = 1'b0;
    err_set   = 1'b0;
    if (beat) begin
      if (in_sop) begin
        // An SOP outside IDLE cuts the running packet; the beat then starts
        // a fresh packet exactly as it would from IDLE.
        if (state != ST_IDLE) err_set = 1'b1;
        if (admit) begin
          wr_nxt    = 1'b1;
          acc_inc   = 1'b1;
          rem_nxt   = cells - 8'd1;
          state_nxt = in_eop ? ST_IDLE : ST_PASS;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = in_eop ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state)
          ST_IDLE: err_set = 1'b1;
          ST_PASS: begin
            if (rem == 8'd0 && !in_eop) begin
              // More cells than the SOP length promised: the space check
              // no longer covers them, so the tail is discarded.
              err_set   = 1'b1;
              state_nxt = ST_DROP;
            end else begin
              wr_nxt  = 1'b1;
              rem_nxt = rem - 8'd1;
              if (in_eop) state_nxt = ST_IDLE;
            end
          end
          ST_DROP: if (in_eop) state_nxt = ST_IDLE;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
    if (wr_nxt && fifo_full) begin
      wr_nxt  = 1'b0;
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rem          <= '0;
      in_ready     <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      pkt_acc_cnt  <= '0;
      pkt_drop_cnt <= '0;
      err_sticky   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      in_ready   <= 1'b1;
      fifo_wr_en <= wr_nxt;
      if (wr_nxt) fifo_din <= in_data;
      if (acc_inc) pkt_acc_cnt <= pkt_acc_cnt + 32'd1;
      if (drop_inc) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      if (err_set) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_admit_writer.sv
// Directed bench for pkt_admit_writer: admit-decision table plus multi-cycle packet sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pkt_admit_writer;
  import occamy_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_sop, in_eop;
  logic [DW-1:0]    in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_ready;
  logic [CNT_W-1:0] cfg_thresh, fifo_data_count;
  logic             fifo_full;
  logic [DW-1:0]    fifo_din;
  logic             fifo_wr_en;
  logic [31:0]      pkt_acc_cnt, pkt_drop_cnt;
  logic             err_sticky;

  int errors = 0;
  int checks = 0;
  int exp_acc, exp_drop;

  always #5 clk = ~clk;

  pkt_admit_writer dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .in_data         (in_data),
    .in_len          (in_len),
    .in_ready        (in_ready),
    .cfg_thresh      (cfg_thresh),
    .fifo_data_count (fifo_data_count),
    .fifo_full       (fifo_full),
    .fifo_din        (fifo_din),
    .fifo_wr_en      (fifo_wr_en),
    .pkt_acc_cnt     (pkt_acc_cnt),
    .pkt_drop_cnt    (pkt_drop_cnt),
    .err_sticky      (err_sticky)
  );

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] th;
    logic             admit;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [DW-1:0] cell_dat(input int i);
    logic [31:0] w;
    w = 32'hC000_0000 | i;
    return {4{w}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, then advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [DW-1:0] d, input logic [LEN_W-1:0] l);
    in_valid = v; in_sop = s; in_eop = e; in_data = d; in_len = l;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_wr(input string name, input logic exp_wr, input logic [DW-1:0] exp_din);
    chk({name, ".wr_en"}, 128'(fifo_wr_en), 128'(exp_wr));
    if (exp_wr) chk({name, ".din"}, 128'(fifo_din), 128'(exp_din));
  endtask

  task automatic chk_stats(input string name, input int acc, input int drp, input logic err);
    chk({name, ".acc"}, 128'(pkt_acc_cnt), 128'(acc));
    chk({name, ".drop"}, 128'(pkt_drop_cnt), 128'(drp));
    chk({name, ".err"}, 128'(err_sticky), 128'(err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    // len, data_count, thresh, expected admit
    vecs[0]  = '{11'd64,   9'd0,   9'd256, 1'b1};
    vecs[1]  = '{11'd0,    9'd0,   9'd256, 1'b0};
    vecs[2]  = '{11'd1,    9'd255, 9'd256, 1'b1};
    vecs[3]  = '{11'd17,   9'd255, 9'd256, 1'b0};
    vecs[4]  = '{11'd2047, 9'd0,   9'd256, 1'b1};
    vecs[5]  = '{11'd2047, 9'd129, 9'd256, 1'b0};
    vecs[6]  = '{11'd2047, 9'd128, 9'd256, 1'b1};
    vecs[7]  = '{11'd16,   9'd255, 9'd511, 1'b1};
    vecs[8]  = '{11'd32,   9'd255, 9'd511, 1'b0};
    vecs[9]  = '{11'd48,   9'd10,  9'd12,  1'b0};
    vecs[10] = '{11'd48,   9'd9,   9'd12,  1'b1};
    vecs[11] = '{11'd16,   9'd0,   9'd0,   1'b0};
    vecs[12] = '{11'd16,   9'd300, 9'd511, 1'b0};

    fifo_full = 1'b0;
    fifo_data_count = '0;
    cfg_thresh = 9'd256;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; in_len = '0;

    // Reset state
    rst = 1'b1;
    idle();
    chk("rst.ready", 128'(in_ready), 128'(1'b0));
    chk_wr("rst", 1'b0, '0);
    chk("rst.din", 128'(fifo_din), 128'(0));
    chk_stats("rst", 0, 0, 1'b0);
    rst = 1'b0;
    idle();
    chk("post_rst.ready", 128'(in_ready), 128'(1'b1));

    // Admit decision table, single-beat packets with no write in flight
    exp_acc = 0; exp_drop = 0;
    foreach (vecs[i]) begin
      fifo_data_count = vecs[i].cnt;
      cfg_thresh = vecs[i].th;
      drive(1'b1, 1'b1, 1'b1, cell_dat(100 + i), vecs[i].len);
      chk_wr($sformatf("vec%0d", i), vecs[i].admit, cell_dat(100 + i));
      if (vecs[i].admit) exp_acc++; else exp_drop++;
      idle();
    end
    chk_stats("table", exp_acc, exp_drop, 1'b0);

    // 1: 64B into empty FIFO, 4 writes in order
    do_reset();
    fifo_data_count = '0; cfg_thresh = 9'd256;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 0, b == 3, cell_dat(b), 11'd64);
      chk_wr($sformatf("t1.b%0d", b), 1'b1, cell_dat(b));
    end
    idle();
    chk_wr("t1.after", 1'b0, '0);
    chk_stats("t1", 1, 0, 1'b0);

    // 2: 112B dropped at count 250, then 96B admitted exactly at the limit
    fifo_data_count = 9'd250;
    for (int b = 0; b < 7; b++) begin
      drive(1'b1, b == 0, b == 6, cell_dat(20 + b), 11'd112);
      chk_wr($sformatf("t2a.b%0d", b), 1'b0, '0);
    end
    idle();
    for (int b = 0; b < 6; b++) begin
      drive(1'b1, b == 0, b == 5, cell_dat(30 + b), 11'd96);
      chk_wr($sformatf("t2b.b%0d", b), 1'b1, cell_dat(30 + b));
    end
    idle();
    chk_stats("t2", 2, 1, 1'b0);

    // 3: back-to-back; pending write counts toward occupancy
    cfg_thresh = 9'd100; fifo_data_count = 9'd95;
    drive(1'b1, 1'b1, 1'b1, cell_dat(40), 11'd16);
    chk_wr("t3a.single", 1'b1, cell_dat(40));
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 0, b == 3, cell_dat(41 + b), 11'd64);
      chk_wr($sformatf("t3a.b%0d", b), 1'b1, cell_dat(41 + b));
    end
    idle();
    fifo_data_count = 9'd96;
    drive(1'b1, 1'b1, 1'b1, cell_dat(50), 11'd16);
    chk_wr("t3b.single", 1'b1, cell_dat(50));
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 0, b == 3, cell_dat(51 + b), 11'd64);
      chk_wr($sformatf("t3b.b%0d", b), 1'b0, '0);
    end
    idle();
    chk_stats("t3", 5, 2, 1'b0);

    // 4: in_len=32 but 4 beats: overrun tail discarded
    cfg_thresh = 9'd256; fifo_data_count = '0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 0, b == 3, cell_dat(60 + b), 11'd32);
      chk_wr($sformatf("t4.b%0d", b), b < 2, cell_dat(60 + b));
    end
    idle();
    chk_stats("t4", 6, 2, 1'b1);
    drive(1'b1, 1'b1, 1'b1, cell_dat(65), 11'd16);
    chk_wr("t4.next", 1'b1, cell_dat(65));
    idle();

    // 5a: SOP mid-PASS cuts old packet, new one admitted
    do_reset();
    chk_stats("t5.rst", 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, cell_dat(70), 11'd64);
    chk_wr("t5.old0", 1'b1, cell_dat(70));
    drive(1'b1, 1'b0, 1'b0, cell_dat(71), 11'd64);
    chk_wr("t5.old1", 1'b1, cell_dat(71));
    drive(1'b1, 1'b1, 1'b0, cell_dat(72), 11'd32);
    chk_wr("t5.new0", 1'b1, cell_dat(72));
    drive(1'b1, 1'b0, 1'b1, cell_dat(73), 11'd32);
    chk_wr("t5.new1", 1'b1, cell_dat(73));
    idle();
    chk_stats("t5a", 2, 0, 1'b1);

    // 5b: non-SOP beat in IDLE
    do_reset();
    drive(1'b1, 1'b0, 1'b0, cell_dat(80), 11'd64);
    chk_wr("t5b", 1'b0, '0);
    chk_stats("t5b", 0, 0, 1'b1);

    // Overflow guard: admitted but FIFO reports full
    do_reset();
    fifo_full = 1'b1;
    drive(1'b1, 1'b1, 1'b1, cell_dat(85), 11'd16);
    chk_wr("ovf", 1'b0, '0);
    chk_stats("ovf", 1, 0, 1'b1);
    fifo_full = 1'b0;

    // 6: reset during beat 2 of a 4-beat packet
    do_reset();
    drive(1'b1, 1'b1, 1'b0, cell_dat(90), 11'd64);
    chk_wr("t6.b0", 1'b1, cell_dat(90));
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, cell_dat(91), 11'd64);
    chk_wr("t6.rst", 1'b0, '0);
    chk("t6.din", 128'(fifo_din), 128'(0));
    chk("t6.ready", 128'(in_ready), 128'(1'b0));
    chk_stats("t6.rst", 0, 0, 1'b0);
    rst = 1'b0;
    idle();
    chk_wr("t6.idle", 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, cell_dat(95), 11'd16);
    chk_wr("t6.new", 1'b1, cell_dat(95));
    idle();
    chk_stats("t6", 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
